// File: rtl/press_classifier.sv
// press_classifier: classifies debounced presses into short, long, double and auto-repeat ticks.
// Define PRESS_REPEAT_EN to enable auto-repeat pulses while a long press is held.
module press_classifier #(
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int GAP_CYCLES    = 12_500_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_W         = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic db_level,
  input  logic db_tick,
  output logic short_tick,
  output logic long_tick,
  output logic double_tick,
  output logic repeat_tick,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, PRESS1, GAP, PRESS2, HELD} state_t;
  localparam logic [CNT_W-1:0] long_t = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] gap_t  = CNT_W'(GAP_CYCLES - 1);
  if ((longint'(1) << CNT_W) <= longint'(LONG_CYCLES) ||
      (longint'(1) << CNT_W) <= longint'(GAP_CYCLES) ||
      (longint'(1) << CNT_W) <= longint'(REPEAT_CYCLES)) begin : g_cnt_w_check
    $error("press_classifier: CNT_W too narrow for cycle parameters");
  end
  state_t state;
  logic [CNT_W-1:0] cnt;
`ifdef PRESS_REPEAT_EN
  localparam logic [CNT_W-1:0] rep_t = CNT_W'(REPEAT_CYCLES - 1);
`else
  assign repeat_tick = 1'b0;
`endif
  // Every transition clears cnt; states that never count keep it at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      short_tick  <= 1'b0;
      long_tick   <= 1'b0;
      double_tick <= 1'b0;
      busy        <= 1'b0;
`ifdef PRESS_REPEAT_EN
      repeat_tick <= 1'b0;
`endif
    end else begin
      short_tick  <= 1'b0;
      long_tick   <= 1'b0;
      double_tick <= 1'b0;
`ifdef PRESS_REPEAT_EN
      repeat_tick <= 1'b0;
`endif
      case (state)
        IDLE: if (db_tick) begin
          state <= PRESS1;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        PRESS1: if (db_level && cnt == long_t) begin
          state     <= HELD;
          cnt       <= '0;
          long_tick <= 1'b1;
        end else if (!db_level) begin
          state <= GAP;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        GAP: if (db_tick) begin
          state       <= PRESS2;
          cnt         <= '0;
          double_tick <= 1'b1;
        end else if (cnt == gap_t) begin
          state      <= IDLE;
          cnt        <= '0;
          short_tick <= 1'b1;
          busy       <= 1'b0;
        end else cnt <= cnt + 1'b1;
        PRESS2: if (!db_level) begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
        HELD: if (!db_level) begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
`ifdef PRESS_REPEAT_EN
        else if (cnt == rep_t) begin
          cnt         <= '0;
          repeat_tick <= 1'b1;
        end else cnt <= cnt + 1'b1;
`endif
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
